// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit.
// Contents: controller state enum, instruction class/subclass codes,
// ALU function-select and register-select codes, and the strobe bundle
// passed from the state decoder to the top level.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RST, ST_F0, ST_F1, ST_F2, ST_F3, ST_DEC,
    ST_E0, ST_E1,
    ST_L0, ST_L1, ST_L2, ST_L3,
    ST_S0, ST_S1, ST_S2, ST_S3,
    ST_B0, ST_B1,
    ST_HALT
  } state_e;

  // irContr[6] selects ALU vs. memory/control class; [5:4] picks the subclass
  localparam logic       CLS_ALU    = 1'b0;
  localparam logic [1:0] SUB_LOAD   = 2'b00;
  localparam logic [1:0] SUB_STORE  = 2'b01;
  localparam logic [1:0] SUB_BRANCH = 2'b10;
  localparam logic [1:0] SUB_HALT   = 2'b11;

  localparam logic [1:0] FN_IR   = 2'b00;
  localparam logic [1:0] FN_ADD  = 2'b01;
  localparam logic [1:0] FN_PASS = 2'b10;

  localparam logic [1:0] SEL_RB   = 2'b00;
  localparam logic [1:0] SEL_RX   = 2'b01;
  localparam logic [1:0] SEL_RDST = 2'b10;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       LPC;
    logic       TPC;
    logic       LT;
    logic       TT;
    logic       LMAR;
    logic       TMAR;
    logic       LIR;
    logic       RMDRExt;
    logic       RMDRInt;
    logic       TMDR2X;
    logic       TMDR2Ext;
    logic       TMDR2IR;
    logic       LMDR;
    logic       LregY;
    logic       T1;
    logic       Lflag;
    logic       PCrst;
    logic [1:0] fnSel;
    logic [1:0] selreg;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
  } strobes_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// State-to-strobe decoder for the CPU control unit.
// Ports:
//   state_i   current registered controller state
//   mem_rdy_i memory completion; gates LIR in F3 and LMDR in L2
//   strb_o    full set of datapath / memory strobes for this cycle
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e   state_i,
  input  logic     mem_rdy_i,
  output strobes_t strb_o
);

  always_comb begin
    strb_o = '0;
    case (state_i)
      ST_RST: strb_o.PCrst = 1'b1;
      ST_F0: begin
        strb_o.TPC   = 1'b1;
        strb_o.fnSel = FN_PASS;
        strb_o.LMAR  = 1'b1;
      end
      ST_F1: begin
        strb_o.TPC   = 1'b1;
        strb_o.LregY = 1'b1;
      end
      ST_F2: begin
        strb_o.T1    = 1'b1;
        strb_o.fnSel = FN_ADD;
        strb_o.LPC   = 1'b1;
      end
      ST_F3: begin
        strb_o.TMAR   = 1'b1;
        strb_o.mem_rd = 1'b1;
        // IR may only capture the bus in the cycle memory actually delivers
        strb_o.LIR    = mem_rdy_i;
      end
      ST_E0, ST_L0, ST_S0: begin
        // E0 reads rx, L0/S0 read rb; the rest is identical
        strb_o.selreg = (state_i == ST_E0) ? SEL_RX : SEL_RB;
        strb_o.rd     = 1'b1;
        strb_o.LregY  = 1'b1;
      end
      ST_E1: begin
        strb_o.selreg = SEL_RB;
        strb_o.rd     = 1'b1;
        strb_o.fnSel  = FN_IR;
        strb_o.wr     = 1'b1;
        strb_o.Lflag  = 1'b1;
      end
      ST_L1, ST_S1: begin
        strb_o.selreg = SEL_RX;
        strb_o.rd     = 1'b1;
        strb_o.fnSel  = FN_ADD;
        strb_o.LMAR   = 1'b1;
      end
      ST_L2: begin
        strb_o.TMAR    = 1'b1;
        strb_o.mem_rd  = 1'b1;
        strb_o.RMDRExt = 1'b1;
        strb_o.LMDR    = mem_rdy_i;
      end
      ST_L3: begin
        strb_o.TMDR2X = 1'b1;
        strb_o.fnSel  = FN_PASS;
        strb_o.wr     = 1'b1;
      end
      ST_S2: begin
        strb_o.selreg  = SEL_RDST;
        strb_o.rd      = 1'b1;
        strb_o.fnSel   = FN_PASS;
        strb_o.RMDRInt = 1'b1;
        strb_o.LMDR    = 1'b1;
      end
      ST_S3: begin
        strb_o.TMAR     = 1'b1;
        strb_o.TMDR2Ext = 1'b1;
        strb_o.mem_wr   = 1'b1;
      end
      ST_B0: begin
        strb_o.TPC   = 1'b1;
        strb_o.LregY = 1'b1;
      end
      ST_B1: begin
        strb_o.selreg = SEL_RB;
        strb_o.rd     = 1'b1;
        strb_o.fnSel  = FN_ADD;
        strb_o.LPC    = 1'b1;
      end
      ST_HALT: strb_o.halted = 1'b1;
      default: strb_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle CPU control unit: fetch / decode / execute sequencer for
// ALU, LOAD, STORE, BRANCH and HALT, with a mem_rdy handshake.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   irContr       IR[15:9] (class bit, subclass / ALU function)
//   Dcondn        branch condition
//   mem_rdy       external memory completes this cycle
//   rd, wr        register bank read / write enables
//   LPC..PCrst    datapath load / transfer strobes
//   fnSel, selreg ALU function select and register select
//   mem_rd/mem_wr external memory strobes, held until mem_rdy
//   halted        high while halted
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] irContr,
  input  logic       Dcondn,
  input  logic       mem_rdy,
  output logic       rd,
  output logic       wr,
  output logic       LPC,
  output logic       TPC,
  output logic       LT,
  output logic       TT,
  output logic       LMAR,
  output logic       TMAR,
  output logic       LIR,
  output logic       RMDRExt,
  output logic       RMDRInt,
  output logic       TMDR2X,
  output logic       TMDR2Ext,
  output logic       TMDR2IR,
  output logic       LMDR,
  output logic       LregY,
  output logic       T1,
  output logic       Lflag,
  output logic       PCrst,
  output logic [1:0] fnSel,
  output logic [1:0] selreg,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted
);

  state_e   state_q, state_d;
  strobes_t strb;

  // The ALU function bits go straight from IR to the datapath
  logic unused_ir;
  assign unused_ir = ^irContr[3:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_F2;
      ST_F2:   state_d = ST_F3;
      ST_F3:   state_d = mem_rdy ? ST_DEC : ST_F3;
      ST_DEC: begin
        if (irContr[6] == CLS_ALU) begin
          state_d = ST_E0;
        end else begin
          case (irContr[5:4])
            SUB_LOAD:   state_d = ST_L0;
            SUB_STORE:  state_d = ST_S0;
            SUB_BRANCH: state_d = Dcondn ? ST_B0 : ST_F0;
            default:    state_d = ST_HALT;
          endcase
        end
      end
      ST_E0:   state_d = ST_E1;
      ST_E1:   state_d = ST_F0;
      ST_L0:   state_d = ST_L1;
      ST_L1:   state_d = ST_L2;
      ST_L2:   state_d = mem_rdy ? ST_L3 : ST_L2;
      ST_L3:   state_d = ST_F0;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_S3:   state_d = mem_rdy ? ST_F0 : ST_S3;
      ST_B0:   state_d = ST_B1;
      ST_B1:   state_d = ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RST;
    else     state_q <= state_d;
  end

  cpu_ctrl_decode u_decode (
    .state_i   (state_q),
    .mem_rdy_i (mem_rdy),
    .strb_o    (strb)
  );

  assign rd       = strb.rd;
  assign wr       = strb.wr;
  assign LPC      = strb.LPC;
  assign TPC      = strb.TPC;
  assign LT       = strb.LT;
  assign TT       = strb.TT;
  assign LMAR     = strb.LMAR;
  assign TMAR     = strb.TMAR;
  assign LIR      = strb.LIR;
  assign RMDRExt  = strb.RMDRExt;
  assign RMDRInt  = strb.RMDRInt;
  assign TMDR2X   = strb.TMDR2X;
  assign TMDR2Ext = strb.TMDR2Ext;
  assign TMDR2IR  = strb.TMDR2IR;
  assign LMDR     = strb.LMDR;
  assign LregY    = strb.LregY;
  assign T1       = strb.T1;
  assign Lflag    = strb.Lflag;
  assign PCrst    = strb.PCrst;
  assign fnSel    = strb.fnSel;
  assign selreg   = strb.selreg;
  assign mem_rd   = strb.mem_rd;
  assign mem_wr   = strb.mem_wr;
  assign halted   = strb.halted;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed tables and sequences plus randomized
// instruction streams checked against an instruction-level sequence model.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] irContr;
  logic       Dcondn;
  logic       mem_rdy;
  logic rd, wr, LPC, TPC, LT, TT, LMAR, TMAR, LIR, RMDRExt, RMDRInt;
  logic TMDR2X, TMDR2Ext, TMDR2IR, LMDR, LregY, T1, Lflag, PCrst;
  logic [1:0] fnSel, selreg;
  logic mem_rd, mem_wr, halted;

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .irContr(irContr), .Dcondn(Dcondn), .mem_rdy(mem_rdy),
    .rd(rd), .wr(wr), .LPC(LPC), .TPC(TPC), .LT(LT), .TT(TT), .LMAR(LMAR),
    .TMAR(TMAR), .LIR(LIR), .RMDRExt(RMDRExt), .RMDRInt(RMDRInt),
    .TMDR2X(TMDR2X), .TMDR2Ext(TMDR2Ext), .TMDR2IR(TMDR2IR), .LMDR(LMDR),
    .LregY(LregY), .T1(T1), .Lflag(Lflag), .PCrst(PCrst), .fnSel(fnSel),
    .selreg(selreg), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted)
  );

  typedef struct packed {
    logic rd, wr, LPC, TPC, LT, TT, LMAR, TMAR, LIR, RMDRExt, RMDRInt;
    logic TMDR2X, TMDR2Ext, TMDR2IR, LMDR, LregY, T1, Lflag, PCrst;
    logic [1:0] fnSel;
    logic [1:0] selreg;
    logic mem_rd, mem_wr, halted;
  } obs_t;

  obs_t obs;
  assign obs = {rd, wr, LPC, TPC, LT, TT, LMAR, TMAR, LIR, RMDRExt, RMDRInt,
                TMDR2X, TMDR2Ext, TMDR2IR, LMDR, LregY, T1, Lflag, PCrst,
                fnSel, selreg, mem_rd, mem_wr, halted};

  typedef enum int {
    T_RST, T_F0, T_F1, T_F2, T_F3, T_DEC, T_E0, T_E1,
    T_L0, T_L1, T_L2, T_L3, T_S0, T_S1, T_S2, T_S3, T_B0, T_B1, T_HALT
  } step_e;

  typedef struct {
    logic  rdy;
    step_e s;
  } cyc_t;

  typedef struct {
    logic       rdy;
    logic [6:0] ir;
    logic       dc;
    obs_t       exp;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;
  cyc_t q[$];
  int l2_rd, lmdr_n, lmdr_bad, lflag_n;

  // Expected strobes for one named step of the instruction sequences
  function automatic obs_t stp(input step_e s, input logic rdy);
    obs_t o = '0;
    case (s)
      T_RST:  o.PCrst = 1'b1;
      T_F0:   begin o.TPC = 1'b1; o.fnSel = 2'b10; o.LMAR = 1'b1; end
      T_F1:   begin o.TPC = 1'b1; o.LregY = 1'b1; end
      T_F2:   begin o.T1 = 1'b1; o.fnSel = 2'b01; o.LPC = 1'b1; end
      T_F3:   begin o.TMAR = 1'b1; o.mem_rd = 1'b1; o.LIR = rdy; end
      T_DEC:  o = '0;
      T_E0:   begin o.selreg = 2'b01; o.rd = 1'b1; o.LregY = 1'b1; end
      T_E1:   begin o.selreg = 2'b00; o.rd = 1'b1; o.wr = 1'b1; o.Lflag = 1'b1; end
      T_L0, T_S0: begin o.selreg = 2'b00; o.rd = 1'b1; o.LregY = 1'b1; end
      T_L1, T_S1: begin o.selreg = 2'b01; o.rd = 1'b1; o.fnSel = 2'b01; o.LMAR = 1'b1; end
      T_L2:   begin o.TMAR = 1'b1; o.mem_rd = 1'b1; o.RMDRExt = 1'b1; o.LMDR = rdy; end
      T_L3:   begin o.TMDR2X = 1'b1; o.fnSel = 2'b10; o.wr = 1'b1; end
      T_S2:   begin o.selreg = 2'b10; o.rd = 1'b1; o.fnSel = 2'b10; o.RMDRInt = 1'b1; o.LMDR = 1'b1; end
      T_S3:   begin o.TMAR = 1'b1; o.TMDR2Ext = 1'b1; o.mem_wr = 1'b1; end
      T_B0:   begin o.TPC = 1'b1; o.LregY = 1'b1; end
      T_B1:   begin o.selreg = 2'b00; o.rd = 1'b1; o.fnSel = 2'b01; o.LPC = 1'b1; end
      T_HALT: o.halted = 1'b1;
      default: o = '1;
    endcase
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // One clock cycle: drive inputs just after the edge, compare shortly after
  task automatic step(input logic rdy, input logic [6:0] ir, input logic dc, input step_e s);
    @(posedge clk);
    #1;
    mem_rdy = rdy; irContr = ir; Dcondn = dc;
    #1;
    chk(s.name(), 32'(obs), 32'(stp(s, rdy)));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1; mem_rdy = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      chk("reset_hold", 32'(obs), 32'(stp(T_RST, 1'b0)));
    end
    rst = 1'b0;
    #1;
    chk("reset_release", 32'(obs), 32'(stp(T_RST, 1'b0)));
  endtask

  task automatic push(input step_e s, input logic rdy);
    cyc_t c;
    c.rdy = rdy; c.s = s;
    q.push_back(c);
  endtask

  task automatic rpush(input step_e s);
    push(s, 1'($urandom));
  endtask

  task automatic mem_wait(input step_e s, input int w);
    for (int i = 0; i < w; i++) push(s, 1'b0);
    push(s, 1'b1);
  endtask

  // Instruction-level model: the step sequence each instruction class runs
  task automatic build(input logic [6:0] ir, input logic dc, input int wf, input int wm);
    rpush(T_F0); rpush(T_F1); rpush(T_F2);
    mem_wait(T_F3, wf);
    rpush(T_DEC);
    if (!ir[6]) begin
      rpush(T_E0); rpush(T_E1);
    end else begin
      case (ir[5:4])
        2'b00: begin rpush(T_L0); rpush(T_L1); mem_wait(T_L2, wm); rpush(T_L3); end
        2'b01: begin rpush(T_S0); rpush(T_S1); rpush(T_S2); mem_wait(T_S3, wm); end
        2'b10: if (dc) begin rpush(T_B0); rpush(T_B1); end
        default: for (int i = 0; i < 6; i++) rpush(T_HALT);
      endcase
    end
  endtask

  task automatic run_q(input logic [6:0] ir, input logic dc, input int n);
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      cyc_t c = q.pop_front();
      step(c.rdy, ir, dc, c.s);
      if (c.s == T_L2 && mem_rd) l2_rd++;
      if (LMDR && c.s == T_L2) begin
        lmdr_n++;
        if (!mem_rdy) lmdr_bad++;
      end
      if (mem_rd && mem_wr) chk("rd_wr_exclusive", 32'(1), 32'(0));
      k++;
    end
  endtask

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ir;
    logic       dc;
    rst = 1'b1; mem_rdy = 1'b0; irContr = '0; Dcondn = 1'b0;

    do_reset(2);

    // ALU op, zero-wait memory, table driven
    tbl[0] = '{1'b1, 7'b0011000, 1'b0, stp(T_F0,  1'b1)};
    tbl[1] = '{1'b1, 7'b0011000, 1'b0, stp(T_F1,  1'b1)};
    tbl[2] = '{1'b1, 7'b0011000, 1'b0, stp(T_F2,  1'b1)};
    tbl[3] = '{1'b1, 7'b0011000, 1'b0, stp(T_F3,  1'b1)};
    tbl[4] = '{1'b1, 7'b0011000, 1'b0, stp(T_DEC, 1'b1)};
    tbl[5] = '{1'b1, 7'b0011000, 1'b0, stp(T_E0,  1'b1)};
    tbl[6] = '{1'b1, 7'b0011000, 1'b0, stp(T_E1,  1'b1)};
    tbl[7] = '{1'b1, 7'b0011000, 1'b0, stp(T_F0,  1'b1)};
    lflag_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      mem_rdy = tbl[i].rdy; irContr = tbl[i].ir; Dcondn = tbl[i].dc;
      #1;
      chk($sformatf("alu_tbl[%0d]", i), 32'(obs), 32'(tbl[i].exp));
      if (Lflag) lflag_n++;
    end
    chk("alu_lflag_once", 32'(lflag_n), 32'(1));

    // LOAD with three wait cycles in L2
    do_reset(1);
    l2_rd = 0; lmdr_n = 0; lmdr_bad = 0;
    build(7'b1000000, 1'b0, 0, 3);
    run_q(7'b1000000, 1'b0, -1);
    step(1'b0, 7'b1000000, 1'b0, T_F0);
    chk("load_l2_mem_rd_cycles", 32'(l2_rd), 32'(4));
    chk("load_lmdr_pulses", 32'(lmdr_n), 32'(1));
    chk("load_lmdr_without_rdy", 32'(lmdr_bad), 32'(0));

    // STORE with one wait cycle
    do_reset(1);
    build(7'b1010000, 1'b0, 1, 1);
    run_q(7'b1010000, 1'b0, -1);
    step(1'b0, 7'b1010000, 1'b0, T_F0);

    // BRANCH not taken then taken, back to back
    do_reset(1);
    build(7'b1100000, 1'b0, 0, 0);
    run_q(7'b1100000, 1'b0, -1);
    build(7'b1100000, 1'b1, 0, 0);
    run_q(7'b1100000, 1'b1, -1);
    step(1'b1, 7'b0000000, 1'b0, T_F0);

    // HALT absorbs, then reset during an L2 wait
    do_reset(1);
    build(7'b1110000, 1'b0, 2, 0);
    run_q(7'b1110000, 1'b0, -1);
    for (int i = 0; i < 3; i++) step(1'($urandom), 7'($urandom), 1'($urandom), T_HALT);
    do_reset(1);
    build(7'b1000000, 1'b0, 0, 6);
    run_q(7'b1000000, 1'b0, 9);
    q.delete();
    do_reset(1);
    chk("reset_mid_l2_mem_rd", 32'(mem_rd), 32'(0));

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      ir = 7'($urandom);
      if (ir[6] && ir[5:4] == 2'b11) ir[4] = 1'b0;
      dc = 1'($urandom);
      build(ir, dc, $urandom_range(0, 3), $urandom_range(0, 3));
      run_q(ir, dc, -1);
    end
    build(7'b1110101, 1'b0, $urandom_range(0, 3), 0);
    run_q(7'b1110101, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
